// File: rtl/cfg_desc_pkg.sv
// Layout constants of the configuration descriptor table and the responder state type.
package cfg_desc_pkg;

  localparam logic [31:0] MAGIC     = 32'h43564136;
  localparam logic [15:0] VERSION   = 16'h0001;
  localparam int unsigned NumFields = 104;

  localparam logic [8:0] F_MAGIC = 9'd0, F_FEATURES = 9'd1, F_CACHE = 9'd2, F_SIZES = 9'd3;
  localparam logic [8:0] F_HALT = 9'd4, F_EXC = 9'd5, F_DMBASE = 9'd6, F_RSVD = 9'd7;
  localparam logic [8:0] F_NONIDEM = 9'd8, F_EXEC = 9'd40, F_CACHED = 9'd72;

  localparam int unsigned FB_RVA = 0, FB_RVB = 1, FB_RVC = 2, FB_RVD = 3, FB_RVF = 4;
  localparam int unsigned FB_RVH = 5, FB_RVS = 6, FB_RVU = 7, FB_RVV = 8, FB_RVZCB = 9;
  localparam int unsigned FB_RVZCMP = 10, FB_RVZICOND = 11, FB_CHERIPURE = 12;
  localparam int unsigned FB_CHERIHYB = 13, FB_CVXIF = 14, FB_DEBUG = 15, FB_MMU = 16;
  localparam int unsigned FB_PERFCNT = 17, FB_FPGA = 18;

  typedef enum logic {IDLE, STREAM} state_e;

endpackage

// File: rtl/config_pkg.sv
// Core configuration record and the two configurations this slice is elaborated with.
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
    bit RVA, RVB, RVC, RVD, RVF, RVH, RVS, RVU, RVV, RVZCB, RVZCMP, RVZiCond;
    bit RVZcheripurecap, RVZcherihybrid, CvxifEn, DebugEn, MmuPresent, PerfCounterEn, FpgaEn;
    int unsigned IcacheByteSize, DcacheByteSize;
    int unsigned NrCommitPorts, NrScoreboardEntries, NrPMPEntries;
    int unsigned NrNonIdempotentRules, NrExecuteRegionRules, NrCachedRegionRules, RASDepth;
    logic [63:0] HaltAddress, ExceptionAddress, DmBaseAddress;
    logic [15:0][63:0] NonIdempotentAddrBase, NonIdempotentLength;
    logic [15:0][63:0] ExecuteRegionAddrBase, ExecuteRegionLength;
    logic [15:0][63:0] CachedRegionAddrBase, CachedRegionLength;
  } cva6_cfg_t;

  // XLEN must stay non-zero so that words-per-field is defined even for the empty config.
  function automatic cva6_cfg_t build_empty_cfg();
    cva6_cfg_t c;
    c = '0;
    c.XLEN = 32;
    return c;
  endfunction

  function automatic cva6_cfg_t build_cv32a6_imac_sv0_cfg();
    cva6_cfg_t c;
    c = '0;
    c.XLEN = 32;
    c.RVA = 1'b1; c.RVC = 1'b1; c.RVS = 1'b1; c.RVU = 1'b1;
    c.DebugEn = 1'b1; c.MmuPresent = 1'b1; c.PerfCounterEn = 1'b1;
    c.IcacheByteSize = 16384; c.DcacheByteSize = 32768;
    c.NrCommitPorts = 2; c.NrScoreboardEntries = 8; c.NrPMPEntries = 8;
    c.NrNonIdempotentRules = 2; c.NrExecuteRegionRules = 3; c.NrCachedRegionRules = 1;
    c.RASDepth = 2;
    c.HaltAddress = 64'h800; c.ExceptionAddress = 64'h808; c.DmBaseAddress = 64'h0;
    c.NonIdempotentAddrBase[0] = 64'h1000_0000; c.NonIdempotentLength[0] = 64'h1000;
    c.NonIdempotentAddrBase[1] = 64'h4000_0000; c.NonIdempotentLength[1] = 64'h1000_0000;
    c.ExecuteRegionAddrBase[0] = 64'h0;         c.ExecuteRegionLength[0] = 64'h1000;
    c.ExecuteRegionAddrBase[1] = 64'h1_0000;    c.ExecuteRegionLength[1] = 64'h1_0000;
    c.ExecuteRegionAddrBase[2] = 64'h8000_0000; c.ExecuteRegionLength[2] = 64'h4000_0000;
    c.CachedRegionAddrBase[0]  = 64'h8000_0000; c.CachedRegionLength[0]  = 64'h4000_0000;
    return c;
  endfunction

  localparam cva6_cfg_t cva6_cfg_empty   = build_empty_cfg();
  localparam cva6_cfg_t cv32a6_imac_sv0  = build_cv32a6_imac_sv0_cfg();

endpackage

// File: rtl/cfg_desc_rom.sv
// Combinational descriptor table: 9-bit word index in, {err, XLEN-bit word} out.
module cfg_desc_rom
  import config_pkg::*;
  import cfg_desc_pkg::*;
#(
  parameter cva6_cfg_t CVA6Cfg = cva6_cfg_empty
) (
  input  logic [8:0]              idx_i,
  output logic                    err_o,
  output logic [CVA6Cfg.XLEN-1:0] data_o
);

  localparam int unsigned XLEN     = CVA6Cfg.XLEN;
  localparam int unsigned WPF      = 64 / XLEN;
  localparam logic [8:0]  NumWords = 9'(NumFields * WPF);

  // Region fields come in base/length pairs; rules past the configured count read as zero.
  function automatic logic [63:0] region_field(input logic [8:0] f, input logic [8:0] first,
                                               input logic [15:0][63:0] base,
                                               input logic [15:0][63:0] len,
                                               input int unsigned nr);
    logic [8:0] k;
    k = (f - first) >> 1;
    if (k >= 9'(nr)) return '0;
    return f[0] ? len[k[3:0]] : base[k[3:0]];
  endfunction

  function automatic logic [63:0] field_value(input logic [8:0] f);
    logic [63:0] v;
    v = '0;
    if (f >= F_CACHED)
      v = region_field(f, F_CACHED, CVA6Cfg.CachedRegionAddrBase, CVA6Cfg.CachedRegionLength,
                       CVA6Cfg.NrCachedRegionRules);
    else if (f >= F_EXEC)
      v = region_field(f, F_EXEC, CVA6Cfg.ExecuteRegionAddrBase, CVA6Cfg.ExecuteRegionLength,
                       CVA6Cfg.NrExecuteRegionRules);
    else if (f >= F_NONIDEM)
      v = region_field(f, F_NONIDEM, CVA6Cfg.NonIdempotentAddrBase, CVA6Cfg.NonIdempotentLength,
                       CVA6Cfg.NrNonIdempotentRules);
    else begin
      case (f)
        F_MAGIC: v = {16'h0, VERSION, MAGIC};
        F_FEATURES: begin
          v[FB_RVA] = CVA6Cfg.RVA;  v[FB_RVB] = CVA6Cfg.RVB;  v[FB_RVC] = CVA6Cfg.RVC;
          v[FB_RVD] = CVA6Cfg.RVD;  v[FB_RVF] = CVA6Cfg.RVF;  v[FB_RVH] = CVA6Cfg.RVH;
          v[FB_RVS] = CVA6Cfg.RVS;  v[FB_RVU] = CVA6Cfg.RVU;  v[FB_RVV] = CVA6Cfg.RVV;
          v[FB_RVZCB] = CVA6Cfg.RVZCB;          v[FB_RVZCMP] = CVA6Cfg.RVZCMP;
          v[FB_RVZICOND] = CVA6Cfg.RVZiCond;    v[FB_CHERIPURE] = CVA6Cfg.RVZcheripurecap;
          v[FB_CHERIHYB] = CVA6Cfg.RVZcherihybrid; v[FB_CVXIF] = CVA6Cfg.CvxifEn;
          v[FB_DEBUG] = CVA6Cfg.DebugEn;        v[FB_MMU] = CVA6Cfg.MmuPresent;
          v[FB_PERFCNT] = CVA6Cfg.PerfCounterEn; v[FB_FPGA] = CVA6Cfg.FpgaEn;
        end
        F_CACHE: v = {CVA6Cfg.IcacheByteSize, CVA6Cfg.DcacheByteSize};
        F_SIZES: v = {8'h0, 8'(CVA6Cfg.RASDepth), 8'(CVA6Cfg.NrCachedRegionRules),
                      8'(CVA6Cfg.NrExecuteRegionRules), 8'(CVA6Cfg.NrNonIdempotentRules),
                      8'(CVA6Cfg.NrPMPEntries), 8'(CVA6Cfg.NrScoreboardEntries),
                      8'(CVA6Cfg.NrCommitPorts)};
        F_HALT:   v = CVA6Cfg.HaltAddress;
        F_EXC:    v = CVA6Cfg.ExceptionAddress;
        F_DMBASE: v = CVA6Cfg.DmBaseAddress;
        F_RSVD:   v = '0;
        default:  v = '0;
      endcase
    end
    return v;
  endfunction

  logic [8:0]  field_idx;
  logic [8:0]  half;
  logic [63:0] field;

  // Each field spans WPF words, low half first.
  always_comb begin
    field_idx = idx_i / 9'(WPF);
    half      = idx_i % 9'(WPF);
    field     = field_value(field_idx);
    err_o     = (idx_i >= NumWords);
    data_o    = err_o ? '0 : XLEN'(field >> (half * 9'(XLEN)));
  end

endmodule

// File: rtl/cva6_cfg_desc_resp.sv
// Burst responder streaming words of the configuration descriptor table, one beat per cycle.
module cva6_cfg_desc_resp
  import config_pkg::*;
  import cfg_desc_pkg::*;
#(
  parameter cva6_cfg_t CVA6Cfg = cva6_cfg_empty
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [7:0]              req_index_i,
  input  logic [3:0]              req_len_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [CVA6Cfg.XLEN-1:0] resp_data_o,
  output logic                    resp_err_o,
  output logic                    resp_last_o
);

  localparam int unsigned XLEN = CVA6Cfg.XLEN;

  state_e          state_q, state_d;
  logic [8:0]      idx_q, idx_d, rom_idx;
  logic [3:0]      rem_q, rem_d;
  logic            valid_q, valid_d, err_q, err_d, last_q, last_d;
  logic [XLEN-1:0] data_q, data_d, rom_data;
  logic            rom_err, req_hs, beat_hs;

  cfg_desc_rom #(.CVA6Cfg(CVA6Cfg)) i_rom (
    .idx_i  (rom_idx),
    .err_o  (rom_err),
    .data_o (rom_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_hs) state_d = STREAM;
      STREAM:  if (flush_i || (beat_hs && last_q)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == IDLE) && !flush_i;
    req_hs      = req_valid_i && req_ready_o;
    beat_hs     = (state_q == STREAM) && resp_ready_i;
  end

  // The index never wraps: past-the-end words simply report err until the burst ends.
  always_comb begin
    idx_d   = idx_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    last_d  = last_q;
    rom_idx = (state_q == IDLE) ? {1'b0, req_index_i} : idx_q + 9'd1;
    if (flush_i || (beat_hs && last_q)) begin
      valid_d = 1'b0;
      data_d  = '0;
      err_d   = 1'b0;
      last_d  = 1'b0;
    end else if (req_hs) begin
      idx_d   = rom_idx;
      rem_d   = req_len_i;
      valid_d = 1'b1;
      data_d  = rom_data;
      err_d   = rom_err;
      last_d  = (req_len_i == 4'd0);
    end else if (beat_hs) begin
      idx_d   = rom_idx;
      rem_d   = rem_q - 4'd1;
      data_d  = rom_data;
      err_d   = rom_err;
      last_d  = (rem_q == 4'd1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  assign resp_valid_o = valid_q;
  assign resp_data_o  = data_q;
  assign resp_err_o   = err_q;
  assign resp_last_o  = last_q;

endmodule

// File: tb/tb_cva6_cfg_desc_resp.sv
// Bench for the descriptor responder under the cv32a6_imac_sv0 configuration.
module tb_cva6_cfg_desc_resp;
  import config_pkg::*;

  localparam cva6_cfg_t Cfg = cv32a6_imac_sv0;

  logic        clk = 1'b0, rst = 1'b0, flush = 1'b0, req_valid = 1'b0, resp_ready = 1'b0;
  logic [7:0]  req_index = '0;
  logic [3:0]  req_len = '0;
  logic        req_ready, resp_valid, resp_err, resp_last;
  logic [31:0] resp_data;

  int          errors = 0, checks = 0;
  logic [63:0] fields [104];
  logic [31:0] q_data [$];
  logic        q_err [$];
  logic        q_last [$];

  cva6_cfg_desc_resp #(.CVA6Cfg(Cfg)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_index_i  (req_index),
    .req_len_i    (req_len),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .resp_err_o   (resp_err),
    .resp_last_o  (resp_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference table built directly from the field layout rules.
  task automatic build_model();
    for (int i = 0; i < 104; i++) fields[i] = '0;
    fields[0] = {16'h0, 16'h0001, 32'h43564136};
    fields[1][0] = Cfg.RVA;   fields[1][1] = Cfg.RVB;   fields[1][2] = Cfg.RVC;
    fields[1][3] = Cfg.RVD;   fields[1][4] = Cfg.RVF;   fields[1][5] = Cfg.RVH;
    fields[1][6] = Cfg.RVS;   fields[1][7] = Cfg.RVU;   fields[1][8] = Cfg.RVV;
    fields[1][9] = Cfg.RVZCB; fields[1][10] = Cfg.RVZCMP; fields[1][11] = Cfg.RVZiCond;
    fields[1][12] = Cfg.RVZcheripurecap; fields[1][13] = Cfg.RVZcherihybrid;
    fields[1][14] = Cfg.CvxifEn; fields[1][15] = Cfg.DebugEn; fields[1][16] = Cfg.MmuPresent;
    fields[1][17] = Cfg.PerfCounterEn; fields[1][18] = Cfg.FpgaEn;
    fields[2] = {Cfg.IcacheByteSize, Cfg.DcacheByteSize};
    fields[3] = {8'h0, 8'(Cfg.RASDepth), 8'(Cfg.NrCachedRegionRules),
                 8'(Cfg.NrExecuteRegionRules), 8'(Cfg.NrNonIdempotentRules),
                 8'(Cfg.NrPMPEntries), 8'(Cfg.NrScoreboardEntries), 8'(Cfg.NrCommitPorts)};
    fields[4] = Cfg.HaltAddress;
    fields[5] = Cfg.ExceptionAddress;
    fields[6] = Cfg.DmBaseAddress;
    for (int k = 0; k < 16; k++) begin
      if (k < int'(Cfg.NrNonIdempotentRules)) begin
        fields[8 + 2*k] = Cfg.NonIdempotentAddrBase[k];
        fields[9 + 2*k] = Cfg.NonIdempotentLength[k];
      end
      if (k < int'(Cfg.NrExecuteRegionRules)) begin
        fields[40 + 2*k] = Cfg.ExecuteRegionAddrBase[k];
        fields[41 + 2*k] = Cfg.ExecuteRegionLength[k];
      end
      if (k < int'(Cfg.NrCachedRegionRules)) begin
        fields[72 + 2*k] = Cfg.CachedRegionAddrBase[k];
        fields[73 + 2*k] = Cfg.CachedRegionLength[k];
      end
    end
  endtask

  function automatic void model_word(input int idx, output logic [31:0] d, output logic e);
    if (idx >= 208) begin
      d = '0;
      e = 1'b1;
    end else begin
      e = 1'b0;
      d = (idx % 2 == 1) ? fields[idx/2][63:32] : fields[idx/2][31:0];
    end
  endfunction

  // mode 0: always ready, 1: random stalls, 2: three stall cycles on beat 1
  task automatic burst(input int idx, input int len, input int mode);
    int          beats, cyc, hold;
    bit          rdy, stalled;
    logic [31:0] pd, ed;
    logic        pe, pl, ee;
    q_data.delete(); q_err.delete(); q_last.delete();
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_index = idx[7:0]; req_len = len[3:0];
    @(negedge clk);
    req_valid = 1'b0;
    beats = 0; cyc = 0; hold = 3; stalled = 1'b0; pd = '0; pe = 1'b0; pl = 1'b0;
    while (beats <= len) begin
      check("resp_valid_in_burst", resp_valid, 1);
      if (resp_valid !== 1'b1 || cyc > 200) break;
      if (stalled) begin
        check("hold_data", resp_data, pd);
        check("hold_err", resp_err, pe);
        check("hold_last", resp_last, pl);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 2) != 0);
        default: rdy = !(beats == 1 && hold > 0);
      endcase
      if (mode == 2 && !rdy) hold--;
      resp_ready = rdy;
      if (rdy) begin
        q_data.push_back(resp_data); q_err.push_back(resp_err); q_last.push_back(resp_last);
        beats++;
      end
      stalled = !rdy; pd = resp_data; pe = resp_err; pl = resp_last;
      @(negedge clk);
      cyc++;
    end
    resp_ready = 1'b0;
    check("valid_after_last", resp_valid, 0);
    check("beat_count", q_data.size(), len + 1);
    for (int b = 0; b < q_data.size(); b++) begin
      model_word(idx + b, ed, ee);
      check("beat_data", q_data[b], ed);
      check("beat_err", q_err[b], ee);
      check("beat_last", q_last[b], (b == len));
    end
  endtask

  initial begin
    int ridx, rlen;
    build_model();

    #1 rst = 1'b1;
    #2;
    check("rst_valid", resp_valid, 0);
    check("rst_data", resp_data, 0);
    check("rst_err", resp_err, 0);
    check("rst_last", resp_last, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("ready_after_rst", req_ready, 1);

    burst(0, 1, 0);
    check("magic_word", q_data[0], 32'h43564136);
    check("version_word", q_data[1], 32'h00000001);
    check("magic_last0", q_last[0], 0);
    check("magic_last1", q_last[1], 1);
    check("magic_err", q_err[0], 0);

    burst(2, 0, 0);
    check("features_word", q_data[0], 32'h000380C5);
    check("features_last", q_last[0], 1);

    burst(84, 3, 2);
    check("exec1_b0", q_data[0], 32'h00010000);
    check("exec1_b1", q_data[1], 32'h0);
    check("exec1_b2", q_data[2], 32'h00010000);
    check("exec1_b3", q_data[3], 32'h0);
    check("exec1_last", q_last[3], 1);

    burst(207, 1, 0);
    check("end_b0_err", q_err[0], 0);
    check("end_b1_data", q_data[1], 0);
    check("end_b1_err", q_err[1], 1);
    check("end_b1_last", q_last[1], 1);

    burst(254, 3, 1);
    for (int b = 0; b < 4; b++) check("nowrap_err", q_err[b], 1);

    // flush on beat 2 of a 16-beat burst
    @(negedge clk);
    req_valid = 1'b1; req_index = 8'd8; req_len = 4'd15;
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_flush_valid", resp_valid, 1);
    check("pre_flush_data", resp_data, fields[5][31:0]);
    flush = 1'b1;
    #1 check("flush_blocks_ready", req_ready, 0);
    @(negedge clk);
    flush = 1'b0; resp_ready = 1'b0;
    check("flush_valid", resp_valid, 0);
    check("flush_last", resp_last, 0);

    // flush coinciding with a request wins
    @(negedge clk);
    req_valid = 1'b1; req_index = 8'd0; req_len = 4'd0; flush = 1'b1;
    #1 check("flush_req_ready", req_ready, 0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("flush_req_valid", resp_valid, 0);

    // reset in the middle of a burst
    @(negedge clk);
    req_valid = 1'b1; req_index = 8'd0; req_len = 4'd7;
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    check("mid_burst_valid", resp_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", resp_valid, 0);
    check("async_rst_data", resp_data, 0);
    check("async_rst_err", resp_err, 0);
    check("async_rst_last", resp_last, 0);
    resp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 check("ready_after_midrst", req_ready, 1);
    burst(0, 0, 0);
    check("magic_after_rst", q_data[0], 32'h43564136);

    for (int n = 0; n < 20; n++) begin
      ridx = $urandom_range(0, 255);
      rlen = $urandom_range(0, 15);
      burst(ridx, rlen, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cva6_cfg_desc_resp.md
CVA6_CFG_DESC_RESP -- requirements
Module: cva6_cfg_desc_resp

Interface
REQ-001 The block SHALL take parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, the core configuration it publishes; XLEN is CVA6Cfg.XLEN and WPF (words per field) is 64/XLEN.
REQ-002 The block SHALL have exactly one clock and an asynchronous, active-high reset: clk_i  in  1  clock; rst_i  in  1  asynchronous active-high reset.
REQ-003 The block SHALL have these data ports:
- flush_i  in  1  synchronous abort of any burst.
- req_valid_i  in  1  burst request valid.
- req_ready_o  out  1  request accepted when valid and ready.
- req_index_i  in  8  start word index.
- req_len_i  in  4  beats minus one (1..16 beats).
- resp_valid_o  out  1  beat valid.
- resp_ready_i  in  1  beat consumed.
- resp_data_o  out  XLEN  beat data.
- resp_err_o  out  1  beat index out of table.
- resp_last_o  out  1  final beat of burst.

Function
REQ-004 The table SHALL be 104 64-bit fields, each occupying WPF consecutive words, low half first, so there are 104*WPF words in total.
REQ-005 Fields F0 to F7 SHALL be:
- F0: {16'h0, version 16'h0001, magic 32'h43564136}.
- F1: feature bits. RVA b0, RVB b1, RVC b2, RVD b3, RVF b4, RVH b5, RVS b6, RVU b7, RVV b8, RVZCB b9, RVZCMP b10, RVZiCond b11, RVZcheripurecap b12, RVZcherihybrid b13, CvxifEn b14, DebugEn b15, MmuPresent b16, PerfCounterEn b17, FpgaEn b18. All other bits are 0.
- F2: {IcacheByteSize[31:0], DcacheByteSize[31:0]}.
- F3: bytes 0..6 hold NrCommitPorts, NrScoreboardEntries, NrPMPEntries, NrNonIdempotentRules, NrExecuteRegionRules, NrCachedRegionRules, RASDepth (each truncated to 8 bits).
- F4: HaltAddress. F5: ExceptionAddress. F6: DmBaseAddress. F7: 0.
REQ-006 For k in 0..15, fields F8+2k / F9+2k SHALL be NonIdempotent base / length, F40+2k / F41+2k Execute base / length, and F72+2k / F73+2k Cached base / length.
REQ-007 A region rule with k at or above its Nr*Rules count SHALL read 0 with resp_err_o=0.
REQ-008 The FSM SHALL have two states, IDLE and STREAM; req_ready_o SHALL be 1 only in IDLE with flush_i=0.
REQ-009 On request handshake, the FSM SHALL enter STREAM and present beat 0 (index req_index_i) on the next cycle, one-cycle latency, registered outputs.
REQ-010 In STREAM, resp_valid_o SHALL be 1, and data/err/last SHALL hold stable while resp_ready_i=0.
REQ-011 On a beat handshake that is not the last, the next beat SHALL appear the following cycle, giving 1 beat/cycle under continuous ready.
REQ-012 resp_last_o SHALL be 1 on beat req_len_i; its handshake SHALL return the FSM to IDLE with resp_valid_o=0, giving one bubble cycle before the next request can be accepted.
REQ-013 The word index SHALL be tracked at 9 bits and SHALL NOT wrap; any index at or above 104*WPF, including past 255, SHALL give data 0 with resp_err_o=1.
REQ-014 Out-of-range beats SHALL NOT terminate the burst; all req_len_i+1 beats are always delivered.
REQ-015 flush_i SHALL force IDLE with resp_valid_o=0 the next cycle; when it coincides with req_valid_i, flush wins and the request is not accepted.
REQ-016 The block SHALL hold no state other than the FSM, the index, the remaining count and the output register.

Reset
REQ-017 Asserting rst_i SHALL immediately clear the outputs: state=IDLE, resp_valid_o=0, resp_data_o=0, resp_err_o=0, resp_last_o=0, index=0, remaining=0.
REQ-018 Reset mid-burst SHALL discard the burst; req_ready_o SHALL be 1 in the first cycle after rst_i deasserts.

Structure
REQ-019 Package cfg_desc_pkg SHALL hold the magic, the version, the field-index constants (F_*), the feature-bit positions, NumFields=104, and the state enum.
REQ-020 Combinational sub-module cfg_desc_rom SHALL map a 9-bit word index to {err, data}; the FSM and registers SHALL reside in cva6_cfg_desc_resp.

Verification
Scenarios use the cv32a6_imac_sv0 configuration (XLEN=32, WPF=2).
REQ-021 Request index 0, len 1 -> beats 32'h43564136, 32'h00000001; last on beat 1; err 0.
REQ-022 Request index 2, len 0 -> a single beat 32'h000380C5 with last=1.
REQ-023 Request index 84, len 3 -> beats 32'h00010000, 0, 32'h00010000, 0 (Execute rule 1), last on beat 3; then hold resp_ready_i=0 for 3 cycles mid-burst -> beat stays stable and no beat is lost.
REQ-024 Request index 207, len 1 -> beat 0 err=0; beat 1 data 0, err=1, last=1.
REQ-025 Request index 254, len 3 -> 4 beats all err=1, no wrap to index 0.
REQ-026 flush_i on beat 2 of a 16-beat burst -> resp_valid_o=0 next cycle; assert rst_i during a burst -> outputs 0 at once; after release a new request index 0 returns the magic.
